// File: rtl/enum_type.sv
`timescale 1ns/1ps
// enum_type: shared command/state types for the tetris control path.
//   state_type  - commands to the core and the core's reported state
//   arb_state_t - ctrl_arbiter FSM states
//   btn_pick    - fixed-priority one-hot select among pending buttons
//   btn_cmd     - maps a one-hot button select to its command
package enum_type;

    typedef enum logic [2:0] {
        NONE   = 3'd0,
        LEFT   = 3'd1,
        RIGHT  = 3'd2,
        ROTATE = 3'd3,
        DOWN   = 3'd4,
        DROP   = 3'd5,
        HOLD   = 3'd6,
        WAIT   = 3'd7
    } state_type;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } arb_state_t;

    localparam int GRAV_CNT_W = 26;

    // Round-robin pointer values: which side wins a UART/button tie.
    localparam logic RR_UART = 1'b0;
    localparam logic RR_BTN  = 1'b1;

    // Button bits: [0]RIGHT [1]ROTATE [2]LEFT [3]DROP.
    // Priority DROP > ROTATE > LEFT > RIGHT.
    function automatic logic [3:0] btn_pick(input logic [3:0] pend);
        logic [3:0] sel;
        sel = 4'b0000;
        if (pend[3])      sel = 4'b1000;
        else if (pend[1]) sel = 4'b0010;
        else if (pend[2]) sel = 4'b0100;
        else if (pend[0]) sel = 4'b0001;
        return sel;
    endfunction

    function automatic state_type btn_cmd(input logic [3:0] sel);
        state_type c;
        case (sel)
            4'b1000: c = DROP;
            4'b0010: c = ROTATE;
            4'b0100: c = LEFT;
            4'b0001: c = RIGHT;
            default: c = NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gravity_timer.sv
`timescale 1ns/1ps
// gravity_timer: free-running gravity period counter.
//   clk_50MHz in  system clock
//   reset_n   in  synchronous active-low reset
//   level_i   in  speed level 0..7; period = max(GRAV_BASE>>level, GRAV_MIN)
//   pause_i   in  holds the counter (and suppresses the tick)
//   tick_o    out one-cycle pulse when the counter wraps
module gravity_timer
    import enum_type::*;
#(
    parameter int GRAV_BASE = 50_000_000,
    parameter int GRAV_MIN  = 2_500_000
) (
    input  logic       clk_50MHz,
    input  logic       reset_n,
    input  logic [2:0] level_i,
    input  logic       pause_i,
    output logic       tick_o
);

    localparam logic [GRAV_CNT_W-1:0] BASE_P = GRAV_CNT_W'(GRAV_BASE);
    localparam logic [GRAV_CNT_W-1:0] MIN_P  = GRAV_CNT_W'(GRAV_MIN);

    logic [GRAV_CNT_W-1:0] cnt_q, cnt_d;
    logic [GRAV_CNT_W-1:0] shifted;
    logic [GRAV_CNT_W-1:0] period;

    always_comb begin
        shifted = BASE_P >> level_i;
        period  = (shifted < MIN_P) ? MIN_P : shifted;
        // '>=' rather than '==' so a level increase that leaves the counter
        // beyond the new period fires on the very next compare.
        tick_o  = !pause_i && (cnt_q >= period - GRAV_CNT_W'(1));
        cnt_d   = cnt_q;
        if (tick_o)
            cnt_d = '0;
        else if (!pause_i)
            cnt_d = cnt_q + GRAV_CNT_W'(1);
    end

    always_ff @(posedge clk_50MHz) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ctrl_arbiter.sv
`timescale 1ns/1ps
// ctrl_arbiter: schedules button, UART and gravity commands onto the single
// tetris-core ctrl port, one at a time, holding each until the core acks.
//   clk_50MHz   in  system clock
//   reset_n     in  synchronous active-low reset
//   btn_pulse   in  one-cycle presses [0]RIGHT [1]ROTATE [2]LEFT [3]DROP
//   uart_valid  in  UART command valid
//   uart_cmd    in  decoded UART command (NONE is accepted and dropped)
//   uart_ready  out one-deep UART buffer empty
//   pause       in  freezes gravity and blocks new grants
//   level       in  speed level 0..7
//   core_state  in  core state; WAIT means idle
//   ctrl        out command to the core for exactly one cycle, else NONE
//   busy        out FSM not in IDLE
//   timeout_err out one-cycle pulse when a command is abandoned
module ctrl_arbiter
    import enum_type::*;
#(
    parameter int GRAV_BASE    = 50_000_000,
    parameter int GRAV_MIN     = 2_500_000,
    parameter int ACK_TIMEOUT  = 1024,
    parameter int DONE_TIMEOUT = 65536
) (
    input  logic       clk_50MHz,
    input  logic       reset_n,
    input  logic [3:0] btn_pulse,
    input  logic       uart_valid,
    input  state_type  uart_cmd,
    output logic       uart_ready,
    input  logic       pause,
    input  logic [2:0] level,
    input  state_type  core_state,
    output state_type  ctrl,
    output logic       busy,
    output logic       timeout_err
);

    localparam int TMR_MAX = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT : DONE_TIMEOUT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    arb_state_t       state_q, state_d;
    state_type        cmd_q, cmd_d;
    state_type        uart_cmd_q, uart_cmd_d;
    logic             uart_full_q, uart_full_d;
    logic [3:0]       btn_pend_q, btn_pend_d;
    logic             grav_pend_q, grav_pend_d;
    logic             rr_q, rr_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic       grav_tick;
    logic       can_grant;
    logic       grant_grav, grant_uart, grant_btn;
    logic [3:0] btn_sel;
    logic       uart_load;

    gravity_timer #(
        .GRAV_BASE (GRAV_BASE),
        .GRAV_MIN  (GRAV_MIN)
    ) u_grav (
        .clk_50MHz (clk_50MHz),
        .reset_n   (reset_n),
        .level_i   (level),
        .pause_i   (pause),
        .tick_o    (grav_tick)
    );

    assign uart_ready = !uart_full_q;
    assign busy       = (state_q != IDLE);
    assign ctrl       = (state_q == ISSUE) ? cmd_q : NONE;

    always_comb begin
        btn_sel    = btn_pick(btn_pend_q);
        can_grant  = (state_q == IDLE) && (core_state == WAIT) && !pause;
        grant_grav = 1'b0;
        grant_uart = 1'b0;
        grant_btn  = 1'b0;
        if (can_grant) begin
            if (grav_pend_q)
                grant_grav = 1'b1;
            else if (uart_full_q && (rr_q == RR_UART || btn_pend_q == 4'b0000))
                grant_uart = 1'b1;
            else if (btn_pend_q != 4'b0000)
                grant_btn = 1'b1;
        end

        // Set terms are OR'd in last so a request on its own grant cycle survives.
        grav_pend_d = (grav_pend_q & ~grant_grav) | grav_tick;
        btn_pend_d  = (btn_pend_q & ~(grant_btn ? btn_sel : 4'b0000)) | btn_pulse;

        // uart_load implies an empty buffer, so it never collides with grant_uart.
        uart_load   = uart_valid && uart_ready && (uart_cmd != NONE);
        uart_full_d = uart_full_q;
        uart_cmd_d  = uart_cmd_q;
        if (grant_uart)
            uart_full_d = 1'b0;
        if (uart_load) begin
            uart_full_d = 1'b1;
            uart_cmd_d  = uart_cmd;
        end

        rr_d = rr_q;
        if (grant_uart || grant_btn)
            rr_d = ~rr_q;

        state_d     = state_q;
        cmd_d       = cmd_q;
        timeout_err = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_grav || grant_uart || grant_btn) begin
                    state_d = ISSUE;
                    if (grant_grav)      cmd_d = DOWN;
                    else if (grant_uart) cmd_d = uart_cmd_q;
                    else                 cmd_d = btn_cmd(btn_sel);
                end
            end
            ISSUE: state_d = WAIT_ACK;
            WAIT_ACK: begin
                if (core_state != WAIT)
                    state_d = WAIT_DONE;
                else if (timer_q == TMR_W'(ACK_TIMEOUT)) begin
                    state_d     = IDLE;
                    timeout_err = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (core_state == WAIT)
                    state_d = IDLE;
                else if (timer_q == TMR_W'(DONE_TIMEOUT)) begin
                    state_d     = IDLE;
                    timeout_err = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Timer restarts on every state entry and only runs in the wait states.
        if (state_d != state_q || state_q == IDLE || state_q == ISSUE)
            timer_d = '0;
        else
            timer_d = timer_q + TMR_W'(1);
    end

    always_ff @(posedge clk_50MHz) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cmd_q       <= NONE;
            uart_cmd_q  <= NONE;
            uart_full_q <= 1'b0;
            btn_pend_q  <= 4'b0000;
            grav_pend_q <= 1'b0;
            rr_q        <= RR_UART;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            uart_cmd_q  <= uart_cmd_d;
            uart_full_q <= uart_full_d;
            btn_pend_q  <= btn_pend_d;
            grav_pend_q <= grav_pend_d;
            rr_q        <= rr_d;
            timer_q     <= timer_d;
        end
    end

endmodule

// File: tb/tb_ctrl_arbiter.sv
`timescale 1ns/1ps
module tb_ctrl_arbiter;
    import enum_type::*;

    logic       clk_50MHz = 1'b0;
    logic       reset_n;
    logic [3:0] btn_pulse;
    logic       uart_valid;
    state_type  uart_cmd;
    logic       uart_ready;
    logic       pause;
    logic [2:0] level;
    state_type  core_state;
    state_type  ctrl;
    logic       busy;
    logic       timeout_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int base  = 0;
    logic core_stuck;
    int   core_cnt;

    ctrl_arbiter #(
        .GRAV_BASE    (1000),
        .GRAV_MIN     (50),
        .ACK_TIMEOUT  (1024),
        .DONE_TIMEOUT (65536)
    ) dut (
        .clk_50MHz   (clk_50MHz),
        .reset_n     (reset_n),
        .btn_pulse   (btn_pulse),
        .uart_valid  (uart_valid),
        .uart_cmd    (uart_cmd),
        .uart_ready  (uart_ready),
        .pause       (pause),
        .level       (level),
        .core_state  (core_state),
        .ctrl        (ctrl),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    always @(posedge clk_50MHz) cyc <= cyc + 1;

    // Core model: echoes a command for 3 cycles, then returns to WAIT.
    always @(posedge clk_50MHz) begin
        if (!reset_n) begin
            core_state <= WAIT;
            core_cnt   <= 0;
        end else if (core_cnt == 1) begin
            core_state <= WAIT;
            core_cnt   <= 0;
        end else if (core_cnt > 1) begin
            core_cnt <= core_cnt - 1;
        end else if (ctrl != NONE && !core_stuck) begin
            core_state <= ctrl;
            core_cnt   <= 3;
        end
    end

    // k = cycles since the last reset edge, sampled at negedges.
    task automatic do_reset();
        @(negedge clk_50MHz);
        reset_n    = 1'b0;
        btn_pulse  = 4'b0000;
        uart_valid = 1'b0;
        uart_cmd   = NONE;
        pause      = 1'b0;
        level      = 3'd0;
        core_stuck = 1'b0;
        repeat (3) @(negedge clk_50MHz);
        reset_n = 1'b1;
        base    = cyc;
    endtask

    task automatic go_to(input int k);
        while (cyc - base < k) @(negedge clk_50MHz);
    endtask

    // Waits up to 'bound' negedges for a non-NONE ctrl; got=NONE on expiry.
    task automatic wait_cmd(input int bound, output state_type got, output int at);
        got = NONE;
        at  = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk_50MHz);
            if (ctrl !== NONE) begin
                got = ctrl;
                at  = cyc - base;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (ctrl !== NONE)      begin n_bad++; $display("FAIL reset_ctrl: got %0d expected %0d", ctrl, NONE); end
        n_cmp++; if (uart_ready !== 1'b1) begin n_bad++; $display("FAIL reset_uart_ready: got %0b expected 1", uart_ready); end
        n_cmp++; if (busy !== 1'b0)       begin n_bad++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_cmp++; if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL reset_timeout_err: got %0b expected 0", timeout_err); end
    endtask

    task automatic test_gravity();
        state_type got;
        int at;
        do_reset();
        wait_cmd(1100, got, at);
        n_cmp++; if (got !== DOWN || at != 1001) begin n_bad++; $display("FAIL grav_first: got %0d@%0d expected %0d@1001", got, at, DOWN); end
        @(negedge clk_50MHz);
        n_cmp++; if (ctrl !== NONE) begin n_bad++; $display("FAIL grav_one_cycle: got %0d expected %0d", ctrl, NONE); end
        wait_cmd(1100, got, at);
        n_cmp++; if (got !== DOWN || at != 2001) begin n_bad++; $display("FAIL grav_second: got %0d@%0d expected %0d@2001", got, at, DOWN); end
        go_to(2010);
        level = 3'd7;
        wait_cmd(100, got, at);
        n_cmp++; if (got !== DOWN || at != 2051) begin n_bad++; $display("FAIL grav_lvl7_first: got %0d@%0d expected %0d@2051", got, at, DOWN); end
        wait_cmd(100, got, at);
        n_cmp++; if (got !== DOWN || at != 2101) begin n_bad++; $display("FAIL grav_lvl7_period: got %0d@%0d expected %0d@2101", got, at, DOWN); end
    endtask

    task automatic test_level_change();
        state_type got;
        int at;
        do_reset();
        go_to(600);
        level = 3'd7;
        wait_cmd(50, got, at);
        n_cmp++; if (got !== DOWN || at != 602) begin n_bad++; $display("FAIL level_jump: got %0d@%0d expected %0d@602", got, at, DOWN); end
    endtask

    task automatic test_buttons();
        state_type got;
        int at;
        do_reset();
        btn_pulse = 4'b1001;
        @(negedge clk_50MHz);
        btn_pulse = 4'b0000;
        wait_cmd(20, got, at);
        n_cmp++; if (got !== DROP || at != 2) begin n_bad++; $display("FAIL btn_drop: got %0d@%0d expected %0d@2", got, at, DROP); end
        wait_cmd(20, got, at);
        n_cmp++; if (got !== RIGHT || at != 8) begin n_bad++; $display("FAIL btn_right: got %0d@%0d expected %0d@8", got, at, RIGHT); end
    endtask

    task automatic test_round_robin();
        state_type got;
        int at;
        do_reset();
        uart_valid = 1'b1;
        uart_cmd   = ROTATE;
        btn_pulse  = 4'b0100;
        @(negedge clk_50MHz);
        uart_valid = 1'b0;
        btn_pulse  = 4'b0000;
        n_cmp++; if (uart_ready !== 1'b0) begin n_bad++; $display("FAIL rr_uart_full: got %0b expected 0", uart_ready); end
        wait_cmd(10, got, at);
        n_cmp++; if (got !== ROTATE || at != 2) begin n_bad++; $display("FAIL rr_first_uart: got %0d@%0d expected %0d@2", got, at, ROTATE); end
        n_cmp++; if (uart_ready !== 1'b1) begin n_bad++; $display("FAIL rr_uart_freed: got %0b expected 1", uart_ready); end
        uart_valid = 1'b1;
        uart_cmd   = DROP;
        btn_pulse  = 4'b0001;
        @(negedge clk_50MHz);
        uart_valid = 1'b0;
        btn_pulse  = 4'b0000;
        wait_cmd(20, got, at);
        n_cmp++; if (got !== LEFT || at != 8) begin n_bad++; $display("FAIL rr_second_btn: got %0d@%0d expected %0d@8", got, at, LEFT); end
        wait_cmd(20, got, at);
        n_cmp++; if (got !== DROP) begin n_bad++; $display("FAIL rr_then_uart: got %0d expected %0d", got, DROP); end
        wait_cmd(20, got, at);
        n_cmp++; if (got !== RIGHT) begin n_bad++; $display("FAIL rr_then_btn: got %0d expected %0d", got, RIGHT); end
    endtask

    task automatic test_uart_none();
        state_type got;
        int at;
        do_reset();
        uart_valid = 1'b1;
        uart_cmd   = NONE;
        @(negedge clk_50MHz);
        uart_valid = 1'b0;
        n_cmp++; if (uart_ready !== 1'b1) begin n_bad++; $display("FAIL none_ready: got %0b expected 1", uart_ready); end
        wait_cmd(20, got, at);
        n_cmp++; if (got !== NONE) begin n_bad++; $display("FAIL none_not_granted: got %0d expected %0d", got, NONE); end
    endtask

    task automatic test_back_to_back();
        state_type got;
        int at;
        do_reset();
        btn_pulse = 4'b0001;
        @(negedge clk_50MHz);
        btn_pulse = 4'b0001;     // press again on the grant cycle
        @(negedge clk_50MHz);
        btn_pulse = 4'b0000;
        n_cmp++; if (ctrl !== RIGHT) begin n_bad++; $display("FAIL b2b_first: got %0d expected %0d", ctrl, RIGHT); end
        wait_cmd(20, got, at);
        n_cmp++; if (got !== RIGHT || at != 8) begin n_bad++; $display("FAIL b2b_repeat: got %0d@%0d expected %0d@8", got, at, RIGHT); end
        wait_cmd(30, got, at);
        n_cmp++; if (got !== NONE) begin n_bad++; $display("FAIL b2b_no_third: got %0d expected %0d", got, NONE); end
    endtask

    task automatic test_ack_timeout();
        state_type got;
        int at;
        do_reset();
        core_stuck = 1'b1;
        btn_pulse  = 4'b1000;
        @(negedge clk_50MHz);
        btn_pulse  = 4'b0000;
        wait_cmd(10, got, at);
        n_cmp++; if (got !== DROP || at != 2) begin n_bad++; $display("FAIL to_drop: got %0d@%0d expected %0d@2", got, at, DROP); end
        go_to(1026);
        n_cmp++; if (timeout_err !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL to_early: got err=%0b busy=%0b expected err=0 busy=1", timeout_err, busy); end
        @(negedge clk_50MHz);
        n_cmp++; if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL to_pulse: got %0b expected 1", timeout_err); end
        core_stuck = 1'b0;
        btn_pulse  = 4'b0100;
        @(negedge clk_50MHz);
        btn_pulse  = 4'b0000;
        n_cmp++; if (timeout_err !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL to_idle: got err=%0b busy=%0b expected err=0 busy=0", timeout_err, busy); end
        wait_cmd(10, got, at);
        n_cmp++; if (got !== DOWN || at != 1029) begin n_bad++; $display("FAIL to_grav_next: got %0d@%0d expected %0d@1029", got, at, DOWN); end
        wait_cmd(20, got, at);
        n_cmp++; if (got !== LEFT || at != 1035) begin n_bad++; $display("FAIL to_btn_next: got %0d@%0d expected %0d@1035", got, at, LEFT); end
    endtask

    task automatic test_pause();
        state_type got;
        int at;
        logic seen;
        do_reset();
        go_to(1000);
        pause = 1'b1;
        go_to(1500);
        btn_pulse = 4'b1000;
        @(negedge clk_50MHz);
        btn_pulse = 4'b0000;
        seen = 1'b0;
        while (cyc - base < 6000) begin
            @(negedge clk_50MHz);
            if (ctrl !== NONE || busy !== 1'b0) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL pause_blocks: got activity=%0b expected 0", seen); end
        pause = 1'b0;
        wait_cmd(10, got, at);
        n_cmp++; if (got !== DOWN || at != 6001) begin n_bad++; $display("FAIL pause_grav_first: got %0d@%0d expected %0d@6001", got, at, DOWN); end
        wait_cmd(20, got, at);
        n_cmp++; if (got !== DROP || at != 6007) begin n_bad++; $display("FAIL pause_btn_next: got %0d@%0d expected %0d@6007", got, at, DROP); end
        wait_cmd(1100, got, at);
        n_cmp++; if (got !== DOWN || at != 7001) begin n_bad++; $display("FAIL pause_frozen_cnt: got %0d@%0d expected %0d@7001", got, at, DOWN); end
    endtask

    task automatic test_reset_mid();
        state_type got;
        int at;
        do_reset();
        uart_valid = 1'b1;
        uart_cmd   = ROTATE;
        btn_pulse  = 4'b1111;
        @(negedge clk_50MHz);
        uart_valid = 1'b0;
        btn_pulse  = 4'b0000;
        @(negedge clk_50MHz);
        n_cmp++; if (ctrl !== ROTATE) begin n_bad++; $display("FAIL rst_mid_issue: got %0d expected %0d", ctrl, ROTATE); end
        uart_valid = 1'b1;
        uart_cmd   = DROP;
        @(negedge clk_50MHz);
        uart_valid = 1'b0;
        @(negedge clk_50MHz);
        n_cmp++; if (busy !== 1'b1 || uart_ready !== 1'b0) begin n_bad++; $display("FAIL rst_mid_pre: got busy=%0b ready=%0b expected busy=1 ready=0", busy, uart_ready); end
        reset_n = 1'b0;
        @(negedge clk_50MHz);
        n_cmp++; if (ctrl !== NONE || busy !== 1'b0 || uart_ready !== 1'b1 || timeout_err !== 1'b0) begin
            n_bad++; $display("FAIL rst_mid_post: got ctrl=%0d busy=%0b ready=%0b err=%0b expected ctrl=0 busy=0 ready=1 err=0", ctrl, busy, uart_ready, timeout_err);
        end
        reset_n = 1'b1;
        wait_cmd(100, got, at);
        n_cmp++; if (got !== NONE) begin n_bad++; $display("FAIL rst_mid_stale: got %0d@%0d expected %0d", got, at, NONE); end
    endtask

    initial begin
        reset_n    = 1'b0;
        btn_pulse  = 4'b0000;
        uart_valid = 1'b0;
        uart_cmd   = NONE;
        pause      = 1'b0;
        level      = 3'd0;
        core_stuck = 1'b0;
        test_reset();
        test_gravity();
        test_level_change();
        test_buttons();
        test_round_robin();
        test_uart_none();
        test_back_to_back();
        test_ack_timeout();
        test_pause();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
